eth_cmd_receiver: RTL and testbench

- Receive-side counterpart of the packet streamer. Takes the single-data-rate GMII-form receive byte stream (rx_data, rx_ctl) and strips preamble/SFD.
- Filters on destination MAC (own or broadcast), checks length and FCS, and writes the first 64 frame bytes into the 64-byte command memory.
- Raises cmd_ready to the streamer when a valid frame sits in memory; holds it until the streamer acknowledges with cmd_done.

---
 rtl/eth_pkg.sv | 22 ++
 rtl/eth_crc32_d8.sv | 21 ++
 rtl/eth_cmd_receiver.sv | 154 +++++++++++++++
 tb/tb_eth_cmd_receiver.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared constants for the Ethernet command receiver and streamer:
// framing bytes, CRC-32 parameters, length limits and FSM state codes.
package eth_pkg;

    localparam logic [7:0]  PREAMBLE    = 8'h55;
    localparam logic [7:0]  SFD         = 8'hD5;

    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    // IEEE 802.3 generator in LSB-first (reflected) form
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;

    localparam int unsigned MIN_LEN     = 64;
    localparam int unsigned MAX_LEN     = 1522;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_PREAMBLE  = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_CHECK     = 3'd3;
    localparam logic [2:0] ST_DROP      = 3'd4;

endpackage

// File: rtl/eth_crc32_d8.sv
// Combinational byte-wide CRC-32 (reflected) next-state function.
// Shared by the receive FCS checker and the transmit FCS generator.
module eth_crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in ^ {24'h0, data};
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/eth_cmd_receiver.sv
// GMII receive path: strips preamble/SFD, filters on destination MAC, checks
// length and FCS, and stores the first bytes of a valid frame as a command.
module eth_cmd_receiver #(
    parameter int unsigned MEM_AW  = 6,
    parameter int unsigned MIN_LEN = eth_pkg::MIN_LEN,
    parameter int unsigned MAX_LEN = eth_pkg::MAX_LEN
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        rx_data,
    input  logic [1:0]        rx_ctl,
    input  logic [47:0]       mac_addr,
    output logic              cmd_we,
    output logic [MEM_AW-1:0] cmd_addr,
    output logic [7:0]        cmd_data,
    output logic              cmd_ready,
    input  logic              cmd_done,
    output logic [15:0]       frame_count,
    output logic [15:0]       crc_err_count
);

    import eth_pkg::*;

    localparam int unsigned IW = $clog2(MAX_LEN + 2);

    logic [2:0]    state;
    logic [IW-1:0] idx;
    logic [31:0]   crc;
    logic [31:0]   crc_next;
    logic          uc_match;
    logic          bc_match;
    logic          wr_ok;
    logic [7:0]    mac_byte;
    logic          rx_dv;
    logic          rx_er;
    logic          addr_ok;
    logic          len_ok;
    logic          crc_ok;

    assign rx_dv = rx_ctl[0];
    assign rx_er = rx_ctl[1];

    eth_crc32_d8 u_crc (
        .crc_in  (crc),
        .data    (rx_data),
        .crc_out (crc_next)
    );

    always_comb begin
        mac_byte = '0;
        case (idx[2:0])
            3'd0:    mac_byte = mac_addr[47:40];
            3'd1:    mac_byte = mac_addr[39:32];
            3'd2:    mac_byte = mac_addr[31:24];
            3'd3:    mac_byte = mac_addr[23:16];
            3'd4:    mac_byte = mac_addr[15:8];
            3'd5:    mac_byte = mac_addr[7:0];
            default: mac_byte = '0;
        endcase
    end

    assign addr_ok = uc_match | bc_match;
    assign len_ok  = (idx >= IW'(MIN_LEN)) && (idx <= IW'(MAX_LEN));
    assign crc_ok  = (crc == CRC_RESIDUE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            idx           <= '0;
            crc           <= CRC_INIT;
            uc_match      <= 1'b0;
            bc_match      <= 1'b0;
            wr_ok         <= 1'b0;
            cmd_we        <= 1'b0;
            cmd_addr      <= '0;
            cmd_data      <= '0;
            cmd_ready     <= 1'b0;
            frame_count   <= '0;
            crc_err_count <= '0;
        end else begin
            cmd_we <= 1'b0;
            // An accept in ST_CHECK below overrides this clear.
            if (cmd_done) begin
                cmd_ready <= 1'b0;
            end

            case (state)
                ST_IDLE, ST_PREAMBLE: begin
                    if (!rx_dv) begin
                        state <= ST_IDLE;
                    end else if (state == ST_PREAMBLE && rx_er) begin
                        state <= ST_DROP;
                    end else if (rx_data == PREAMBLE) begin
                        state <= ST_PREAMBLE;
                    end else if (rx_data == SFD) begin
                        state    <= ST_DATA;
                        idx      <= '0;
                        crc      <= CRC_INIT;
                        uc_match <= 1'b1;
                        bc_match <= 1'b1;
                        // Writes are locked out for the whole frame if a command is pending at its start.
                        wr_ok    <= ~cmd_ready;
                    end else begin
                        state <= ST_DROP;
                    end
                end

                ST_DATA: begin
                    if (!rx_dv) begin
                        state <= ST_CHECK;
                    end else begin
                        crc <= crc_next;
                        if (idx < IW'(MAX_LEN + 1)) begin
                            idx <= idx + 1'b1;
                        end
                        if (idx < IW'(6)) begin
                            if (rx_data != mac_byte) uc_match <= 1'b0;
                            if (rx_data != 8'hFF)    bc_match <= 1'b0;
                        end
                        if (idx < IW'(2 ** MEM_AW) && wr_ok && !cmd_ready) begin
                            cmd_we   <= 1'b1;
                            cmd_addr <= idx[MEM_AW-1:0];
                            cmd_data <= rx_data;
                        end
                        if (rx_er) begin
                            state <= ST_DROP;
                        end
                    end
                end

                ST_CHECK: begin
                    state <= ST_IDLE;
                    if (addr_ok && len_ok) begin
                        if (crc_ok && wr_ok) begin
                            cmd_ready   <= 1'b1;
                            frame_count <= frame_count + 16'd1;
                        end else if (!crc_ok) begin
                            crc_err_count <= crc_err_count + 16'd1;
                        end
                    end
                end

                ST_DROP: begin
                    if (!rx_dv) begin
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_cmd_receiver.sv
// Scoreboard bench for eth_cmd_receiver: expected memory writes are queued at
// stimulus time and popped by an independent monitor whenever cmd_we is seen.
`timescale 1ns/1ps
module tb_eth_cmd_receiver;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  rx_data;
    logic [1:0]  rx_ctl;
    logic [47:0] mac_addr;
    logic        cmd_we;
    logic [5:0]  cmd_addr;
    logic [7:0]  cmd_data;
    logic        cmd_ready;
    logic        cmd_done;
    logic [15:0] frame_count;
    logic [15:0] crc_err_count;

    always #5 clk = ~clk;

    eth_cmd_receiver #(
        .MEM_AW  (6),
        .MIN_LEN (64),
        .MAX_LEN (1522)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .rx_data       (rx_data),
        .rx_ctl        (rx_ctl),
        .mac_addr      (mac_addr),
        .cmd_we        (cmd_we),
        .cmd_addr      (cmd_addr),
        .cmd_data      (cmd_data),
        .cmd_ready     (cmd_ready),
        .cmd_done      (cmd_done),
        .frame_count   (frame_count),
        .crc_err_count (crc_err_count)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned wr_pulses = 0;
    logic [13:0] exp_wr[$];
    logic [13:0] mon_exp;
    logic [7:0]  frame[$];

    // reference model state
    bit          m_ready;
    int unsigned m_frames;
    int unsigned m_crcerr;

    localparam logic [47:0] OWN_MAC = 48'h00_01_02_03_04_09;
    localparam logic [47:0] BCAST   = 48'hFF_FF_FF_FF_FF_FF;

    always @(negedge clk) begin
        if (reset_n && cmd_we) begin
            wr_pulses++;
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%02h, none expected", cmd_addr, cmd_data);
            end else begin
                mon_exp = exp_wr.pop_front();
                if ({cmd_addr, cmd_data} !== mon_exp) begin
                    errors++;
                    $display("FAIL mem_write: got addr=%0d data=%02h, expected addr=%0d data=%02h",
                             cmd_addr, cmd_data, mon_exp[13:8], mon_exp[7:0]);
                end
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] d, input bit dv, input bit er);
        @(posedge clk);
        #1;
        rx_data = d;
        rx_ctl  = {er, dv};
    endtask

    // Standard LSB-first CRC-32 over the first n frame bytes, final-inverted (the FCS value).
    function automatic logic [31:0] fcs_of(input int unsigned n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < int'(n); i++) begin
            c = c ^ {24'h0, frame[i]};
            for (int b = 0; b < 8; b++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    function automatic logic [7:0] rnd_byte(input bit avoid);
        logic [7:0] b;
        b = 8'($urandom);
        if (avoid && (b == 8'h55 || b == 8'hD5)) b = 8'h3C;
        return b;
    endfunction

    task automatic build_frame(input logic [47:0] da, input int unsigned len, input bit bad_fcs, input bit avoid);
        logic [31:0] f;
        frame.delete();
        for (int i = 0; i < 6; i++) frame.push_back(da[47 - 8*i -: 8]);
        for (int i = 0; i < 6; i++) frame.push_back(rnd_byte(avoid));
        frame.push_back(8'h08);
        frame.push_back(8'h06);
        for (int i = 14; i < int'(len) - 4; i++) frame.push_back(rnd_byte(avoid));
        f = fcs_of(len - 4);
        for (int k = 0; k < 4; k++) frame.push_back(f[8*k +: 8]);
        if (bad_fcs) frame[len-1] = frame[len-1] ^ 8'h01;
    endtask

    task automatic send_frame(input int err_idx, input int rst_idx, input bit done_at_check);
        bit          start_ready;
        bit          addr_ok;
        bit          len_ok;
        bit          fcs_ok;
        int          n;
        int          limit;
        int unsigned pulses0;
        logic [31:0] rx_fcs;

        n = frame.size();
        start_ready = m_ready;
        limit = n;
        if (err_idx >= 0) limit = err_idx + 1;
        if (rst_idx >= 0) limit = rst_idx;
        if (!start_ready) begin
            for (int i = 0; i < limit && i < 64; i++) exp_wr.push_back({6'(i), frame[i]});
        end

        addr_ok = 1'b1;
        for (int i = 0; i < 6; i++) if (frame[i] != mac_addr[47 - 8*i -: 8]) addr_ok = 1'b0;
        if (frame[0] == 8'hFF && frame[1] == 8'hFF && frame[2] == 8'hFF &&
            frame[3] == 8'hFF && frame[4] == 8'hFF && frame[5] == 8'hFF) addr_ok = 1'b1;
        len_ok = (n >= 64) && (n <= 1522);
        rx_fcs = {frame[n-1], frame[n-2], frame[n-3], frame[n-4]};
        fcs_ok = (rx_fcs == fcs_of(n - 4));

        drive(8'h00, 1'b0, 1'b0);
        drive(8'h00, 1'b0, 1'b0);
        pulses0 = wr_pulses;
        for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < n; i++) begin
            if (rst_idx >= 0 && i == rst_idx + 2) reset_n = 1'b1;
            drive(frame[i], 1'b1, (i == err_idx));
            if (i == rst_idx) begin
                #6;
                reset_n = 1'b0;
                #1;
                check("rst_cmd_we",      cmd_we,        0);
                check("rst_cmd_addr",    cmd_addr,      0);
                check("rst_cmd_data",    cmd_data,      0);
                check("rst_cmd_ready",   cmd_ready,     0);
                check("rst_frame_count", frame_count,   0);
                check("rst_crc_err",     crc_err_count, 0);
                m_ready  = 1'b0;
                m_frames = 0;
                m_crcerr = 0;
            end
        end
        drive(8'h00, 1'b0, 1'b0);

        @(posedge clk);
        #1;
        if (done_at_check) cmd_done = 1'b1;
        else check("ready_before_eval", cmd_ready, m_ready);
        @(posedge clk);
        #1;
        cmd_done = 1'b0;

        if (err_idx < 0 && rst_idx < 0 && addr_ok && len_ok) begin
            if (fcs_ok && !start_ready) begin
                m_ready = 1'b1;
                m_frames++;
            end else if (!fcs_ok) begin
                m_crcerr++;
            end
        end
        if (done_at_check && m_ready && !(err_idx < 0 && rst_idx < 0 && addr_ok && len_ok && fcs_ok && !start_ready))
            m_ready = 1'b0;

        check("cmd_ready",     cmd_ready,     m_ready);
        check("frame_count",   frame_count,   16'(m_frames));
        check("crc_err_count", crc_err_count, 16'(m_crcerr));
        check("pending_writes", exp_wr.size(), 0);
        if (start_ready) check("writes_while_ready", wr_pulses - pulses0, 0);
    endtask

    task automatic pulse_done();
        @(posedge clk);
        #1;
        cmd_done = 1'b1;
        @(posedge clk);
        #1;
        cmd_done = 1'b0;
        m_ready = 1'b0;
        check("done_clears_ready", cmd_ready, 0);
    endtask

    initial begin
        reset_n  = 1'b0;
        rx_data  = 8'h00;
        rx_ctl   = 2'b00;
        cmd_done = 1'b0;
        mac_addr = OWN_MAC;
        m_ready  = 1'b0;
        m_frames = 0;
        m_crcerr = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_cmd_we",      cmd_we,        0);
        check("reset_cmd_addr",    cmd_addr,      0);
        check("reset_cmd_data",    cmd_data,      0);
        check("reset_cmd_ready",   cmd_ready,     0);
        check("reset_frame_count", frame_count,   0);
        check("reset_crc_err",     crc_err_count, 0);
        reset_n = 1'b1;

        // broadcast ARP, minimum length
        build_frame(BCAST, 64, 1'b0, 1'b0);
        send_frame(-1, -1, 1'b0);
        pulse_done();

        // unicast to own address
        build_frame(OWN_MAC, 100, 1'b0, 1'b0);
        send_frame(-1, -1, 1'b0);
        pulse_done();

        // unicast to a neighbouring address
        build_frame(48'h00_01_02_03_04_0A, 100, 1'b0, 1'b0);
        send_frame(-1, -1, 1'b0);

        // corrupted FCS
        build_frame(OWN_MAC, 80, 1'b1, 1'b0);
        send_frame(-1, -1, 1'b0);

        // hand-off: A accepted, B blocked while pending, C accepted after cmd_done
        build_frame(OWN_MAC, 70, 1'b0, 1'b0);
        send_frame(-1, -1, 1'b0);
        build_frame(BCAST, 90, 1'b0, 1'b0);
        send_frame(-1, -1, 1'b0);
        pulse_done();
        build_frame(OWN_MAC, 120, 1'b0, 1'b0);
        send_frame(-1, -1, 1'b0);
        pulse_done();

        // cmd_done while nothing pending is ignored
        pulse_done();

        // runt with good FCS, then rx_er mid-frame
        build_frame(BCAST, 40, 1'b0, 1'b0);
        send_frame(-1, -1, 1'b0);
        build_frame(OWN_MAC, 100, 1'b0, 1'b0);
        send_frame(30, -1, 1'b0);

        // length boundaries
        build_frame(OWN_MAC, 63, 1'b0, 1'b0);
        send_frame(-1, -1, 1'b0);
        build_frame(OWN_MAC, 1523, 1'b0, 1'b0);
        send_frame(-1, -1, 1'b0);
        build_frame(OWN_MAC, 1522, 1'b0, 1'b0);
        send_frame(-1, -1, 1'b1);

        // pending command: a bad-FCS frame still counts as an FCS error
        build_frame(OWN_MAC, 66, 1'b1, 1'b0);
        send_frame(-1, -1, 1'b0);
        pulse_done();

        // randomized traffic
        for (int k = 0; k < 14; k++) begin
            logic [47:0] da;
            int unsigned sel;
            sel = $urandom_range(0, 3);
            if (sel == 0)      da = BCAST;
            else if (sel == 3) da = OWN_MAC ^ (48'h1 << $urandom_range(0, 47));
            else               da = OWN_MAC;
            build_frame(da, $urandom_range(60, 200), ($urandom_range(0, 3) == 0), 1'b0);
            send_frame(-1, -1, ($urandom_range(0, 4) == 0));
            if (m_ready && $urandom_range(0, 1) == 1) pulse_done();
        end
        if (m_ready) pulse_done();

        // reset asserted at byte 20, then a clean frame
        build_frame(OWN_MAC, 100, 1'b0, 1'b1);
        send_frame(-1, 20, 1'b0);
        build_frame(OWN_MAC, 64, 1'b0, 1'b0);
        send_frame(-1, -1, 1'b0);
        check("post_reset_frames", frame_count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
